atm_session_controller: RTL and testbench
=========================================

// Module: atm_session_controller
// PURPOSE
// Parametrised next-generation ATM session FSM: card insert, PIN check with lockout, menu,
// withdraw/deposit with balance, daily-limit and step-up authentication (face + OTP), cash
// dispense/accept handshakes, inactivity timeout. Sits between keypad/card/biometric front-ends
// and the cash-handling mechanics; optional mini-statement log.
// PARAMETERS
// BAL_W          16    balance register width (unsigned)
// AMT_W          12    transaction amount width (unsigned, AMT_W <= BAL_W)
// PIN_DIGITS     4     BCD digits per PIN
// MAX_PIN_TRIES  3     consecutive wrong PINs before LOCKED
// AUTH_THRESH    500   withdraw amounts strictly greater need face + OTP
// DAILY_LIMIT    1000  max total withdrawn per card session
// TIMEOUT_CYC    1024  idle cycles before session abort
// LOG_DEPTH      4     mini-statement entries (power of 2)
// PORTS
// clk                        in   1          clock, rising edge
// reset                      in   1          asynchronous, active-high
// card_inserted              in   1          level; low = card absent
// card_pin                   in   4*PIN_DIGITS  PIN from card; sampled on IDLE->PIN
// card_balance               in   BAL_W      balance from card; sampled on IDLE->PIN
// key_valid / key_in         in   1 / 4      keypad strobe / code (0-9 digit, 0xF cancel)
// amount_valid / amount_in   in   1 / AMT_W  amount entry strobe / value
// face_recognition_passed    in   1          biometric pass pulse
// otp_passed / otp_failed    in   1 / 1      OTP result pulses
// dispense_ack / deposit_ack in   1 / 1      cash mechanics completion
// display_data               out  8          {1'b0, error_code[2:0], state_code[3:0]}
// balance                    out  BAL_W      live balance
// dispense_cash / deposit_cash out 1 / 1     request levels, held until matching ack
// txn_amount                 out  AMT_W      amount of current request
// face_recognition_required  out  1          high in AUTH_FACE
// otp_required               out  1          high in AUTH_OTP
// invalid_pin_attempts_exceeded out 1        high in LOCKED
// stmt_valid/stmt_entry/stmt_last out 1/1+AMT_W/1  statement stream {is_deposit, amount}
// BEHAVIOUR
// - Reset: state IDLE; all outputs, balance, counters, log pointers = 0.
// - IDLE: card_inserted -> PIN; latch card_pin, card_balance; tries = 0, session_sum = 0.
// - PIN: key_valid with 0-9 shifts a digit in; key 0xA-0xE ignored; 0xF -> IDLE. After
//   PIN_DIGITS digits, compare next cycle: match -> MENU; mismatch -> tries+1, error 7, clear
//   digits; tries+1 == MAX_PIN_TRIES -> LOCKED.
// - MENU: key 1 -> AMT_W(ithdraw), 2 -> AMT_D(eposit), 4 -> STMT (if enabled), 0xF -> IDLE.
// - AMT_W on amount_valid (checked in order): 0 -> err 1; > balance -> err 2;
//   session_sum+amt > DAILY_LIMIT -> err 3; errors return to MENU. Else amt > AUTH_THRESH ->
//   AUTH_FACE -> (face pass) AUTH_OTP -> (otp_passed) DISPENSE; otp_failed -> MENU, err 5.
//   Else -> DISPENSE directly.
// - DISPENSE: dispense_cash held high; on dispense_ack: balance -= amt, session_sum += amt,
//   log entry, -> MENU. Drop exactly one cycle after ack edge.
// - AMT_D: 0 -> err 1; balance+amt > 2^BAL_W-1 -> err 4; else DEPOSIT: deposit_cash held
//   until deposit_ack; then balance += amt, log, -> MENU.
// - LOCKED: exit to IDLE only when card_inserted low.
// - Timeout: any state except IDLE/LOCKED with no input strobe/ack for TIMEOUT_CYC cycles ->
//   IDLE, err 6; in DISPENSE/DEPOSIT the timer is suspended (mechanics own the timing).
// - Priority: card removal > ack > timeout > key/amount. Removal mid-DISPENSE/DEPOSIT ->
//   IDLE, request dropped, balance unchanged.
// - error_code holds until next key_valid/amount_valid; all arithmetic unsigned, no wrap.
// CONFIGURATION
// - ATM_MINI_STATEMENT_EN defined: circular log of last LOG_DEPTH completed transactions;
//   oldest overwritten when full. STMT streams entries newest-first, one per cycle,
//   stmt_last on final entry, then MENU; empty log -> MENU, no stmt_valid.
// - Undefined: key 4 ignored in MENU, no log storage, stmt_* tied to 0.
// STRUCTURE
// - atm_pkg: state enum + state_code encodings, error codes, key codes (KEY_CANCEL etc.).
// - Sub-module atm_txn_log (circular buffer, write + readout pointer), instantiated only
//   under ATM_MINI_STATEMENT_EN.
// TESTING
// - Insert card pin 1234 bal 800; keys 1,2,3,4 -> MENU; withdraw 200, ack -> balance 600.
// - Wrong PIN x3 -> LOCKED, exceeded=1; card_inserted low -> IDLE, exceeded=0.
// - Withdraw 600 (AUTH_THRESH 500) -> face_req, then otp_req; otp_failed -> MENU, err 5.
// - Withdraw 900 on bal 800 -> err 2; withdraw 600+500 in one session -> second err 3.
// - Deposit 65535-bal+1 -> err 4; card pulled while dispense_cash high -> IDLE, bal kept.
// - ATM_MINI_STATEMENT_EN, 5 txns, LOG_DEPTH 4 -> key 4 streams newest 4, stmt_last on 4th.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared types for the ATM session controller.
// Each state value is also the state nibble shown on the display.
package atm_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_PIN       = 4'd1,
    S_MENU      = 4'd2,
    S_AMT_W     = 4'd3,
    S_AMT_D     = 4'd4,
    S_AUTH_FACE = 4'd5,
    S_AUTH_OTP  = 4'd6,
    S_DISPENSE  = 4'd7,
    S_DEPOSIT   = 4'd8,
    S_LOCKED    = 4'd9,
    S_STMT      = 4'd10
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_ZERO    = 3'd1,
    ERR_FUNDS   = 3'd2,
    ERR_LIMIT   = 3'd3,
    ERR_OVF     = 3'd4,
    ERR_OTP     = 3'd5,
    ERR_TIMEOUT = 3'd6,
    ERR_PIN     = 3'd7
  } err_t;

  localparam logic [3:0] KEY_WDR    = 4'h1;
  localparam logic [3:0] KEY_DEP    = 4'h2;
  localparam logic [3:0] KEY_STMT   = 4'h4;
  localparam logic [3:0] KEY_DIGMAX = 4'h9;
  localparam logic [3:0] KEY_CANCEL = 4'hF;

endpackage

// File: rtl/atm_txn_log.sv
// Circular log of completed transactions, read back newest-first.
// Used only when ATM_MINI_STATEMENT_EN is defined.
module atm_txn_log #(
  parameter int AMT_W = 12,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_we,
  input  logic [AMT_W:0] i_wdata,
  input  logic         i_start,
  input  logic         i_rd,
  output logic         o_empty,
  output logic [AMT_W:0] o_entry,
  output logic         o_last
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AMT_W:0] r_mem [DEPTH];
  logic [AW-1:0]  r_wp;
  logic [AW-1:0]  r_rp;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  r_rem;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[r_wp] <= i_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_rem <= '0;
    end else begin
      if (i_we) begin
        r_wp <= r_wp + AW'(1);
        if (r_cnt != FULL) r_cnt <= r_cnt + CW'(1);
      end
      if (i_start) begin
        r_rp  <= r_wp - AW'(1);
        r_rem <= r_cnt;
      end else if (i_rd) begin
        r_rp  <= r_rp - AW'(1);
        r_rem <= r_rem - CW'(1);
      end
    end
  end

  assign o_empty = (r_cnt == '0);
  assign o_entry = r_mem[r_rp];
  assign o_last  = (r_rem == CW'(1));

endmodule

// File: rtl/atm_session_controller.sv
// ATM session FSM: card, PIN lockout, menu, withdraw/deposit, step-up auth, timeout.
// Define ATM_MINI_STATEMENT_EN to add the mini-statement log and STMT readout.
module atm_session_controller
  import atm_pkg::*;
#(
  parameter int BAL_W         = 16,
  parameter int AMT_W         = 12,
  parameter int PIN_DIGITS    = 4,
  parameter int MAX_PIN_TRIES = 3,
  parameter int AUTH_THRESH   = 500,
  parameter int DAILY_LIMIT   = 1000,
  parameter int TIMEOUT_CYC   = 1024,
  parameter int LOG_DEPTH     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    card_inserted,
  input  logic [4*PIN_DIGITS-1:0] card_pin,
  input  logic [BAL_W-1:0]        card_balance,
  input  logic                    key_valid,
  input  logic [3:0]              key_in,
  input  logic                    amount_valid,
  input  logic [AMT_W-1:0]        amount_in,
  input  logic                    face_recognition_passed,
  input  logic                    otp_passed,
  input  logic                    otp_failed,
  input  logic                    dispense_ack,
  input  logic                    deposit_ack,
  output logic [7:0]              display_data,
  output logic [BAL_W-1:0]        balance,
  output logic                    dispense_cash,
  output logic                    deposit_cash,
  output logic [AMT_W-1:0]        txn_amount,
  output logic                    face_recognition_required,
  output logic                    otp_required,
  output logic                    invalid_pin_attempts_exceeded,
  output logic                    stmt_valid,
  output logic [AMT_W:0]          stmt_entry,
  output logic                    stmt_last
);
  localparam int PW  = 4 * PIN_DIGITS;
  localparam int DW  = $clog2(PIN_DIGITS + 1);
  localparam int TW  = $clog2(MAX_PIN_TRIES + 1);
  localparam int XW  = BAL_W + 1;
  localparam int TMW = $clog2(TIMEOUT_CYC);

  localparam logic [DW-1:0]  DIG_FULL = DW'(PIN_DIGITS);
  localparam logic [TW-1:0]  LAST_TRY = TW'(MAX_PIN_TRIES - 1);
  localparam logic [TMW-1:0] TMO_LAST = TMW'(TIMEOUT_CYC - 1);
  localparam logic [XW-1:0]  X_THR    = XW'(AUTH_THRESH);
  localparam logic [XW-1:0]  X_LIM    = XW'(DAILY_LIMIT);
  localparam logic [XW-1:0]  X_MAX    = {1'b0, {BAL_W{1'b1}}};

  state_t r_state, w_nxt;
  err_t   r_err, w_err;

  logic [PW-1:0]    r_card_pin;
  logic [PW-1:0]    r_digits;
  logic [DW-1:0]    r_dcnt;
  logic [TW-1:0]    r_tries;
  logic [BAL_W-1:0] r_bal;
  logic [BAL_W-1:0] r_sum;
  logic [AMT_W-1:0] r_amt;
  logic [TMW-1:0]   r_tmr;

  logic w_latch, w_shift, w_pin_clr, w_try_inc;
  logic w_amt_ld, w_wdr_done, w_dep_done;
  logic w_evt, w_tmr_on, w_tmo;
  logic [XW-1:0]    w_amt_x, w_bal_x, w_sum_x;
  logic [BAL_W-1:0] w_amt_b;

`ifdef ATM_MINI_STATEMENT_EN
  logic w_stmt_go, w_log_empty, w_log_last;
  logic [AMT_W:0] w_log_entry;
`endif

  assign w_amt_x = XW'(amount_in);
  assign w_bal_x = XW'(r_bal);
  assign w_sum_x = XW'(r_sum);
  assign w_amt_b = BAL_W'(r_amt);

  assign w_evt = key_valid | amount_valid | face_recognition_passed |
                 otp_passed | otp_failed | dispense_ack | deposit_ack;

  // Mechanics own the timing while cash is moving.
  assign w_tmr_on = (r_state != S_IDLE) && (r_state != S_LOCKED) &&
                    (r_state != S_DISPENSE) && (r_state != S_DEPOSIT);
  assign w_tmo = w_tmr_on && !w_evt && (r_tmr == TMO_LAST);

  always_comb begin
    w_nxt      = r_state;
    w_err      = r_err;
    w_latch    = 1'b0;
    w_shift    = 1'b0;
    w_pin_clr  = 1'b0;
    w_try_inc  = 1'b0;
    w_amt_ld   = 1'b0;
    w_wdr_done = 1'b0;
    w_dep_done = 1'b0;
`ifdef ATM_MINI_STATEMENT_EN
    w_stmt_go  = 1'b0;
`endif
    if (key_valid || amount_valid) w_err = ERR_NONE;
    if (r_state != S_IDLE && !card_inserted) begin
      w_nxt = S_IDLE;
    end else if (w_tmo) begin
      w_nxt = S_IDLE;
      w_err = ERR_TIMEOUT;
    end else begin
      unique case (r_state)
        S_IDLE: if (card_inserted) begin
          w_nxt   = S_PIN;
          w_latch = 1'b1;
        end
        S_PIN: if (r_dcnt == DIG_FULL) begin
          if (r_digits == r_card_pin) begin
            w_nxt = S_MENU;
          end else begin
            w_err     = ERR_PIN;
            w_pin_clr = 1'b1;
            w_try_inc = 1'b1;
            if (r_tries == LAST_TRY) w_nxt = S_LOCKED;
          end
        end else if (key_valid) begin
          if (key_in == KEY_CANCEL) w_nxt = S_IDLE;
          else if (key_in <= KEY_DIGMAX) w_shift = 1'b1;
        end
        S_MENU: if (key_valid) begin
          unique case (1'b1)
            key_in == KEY_WDR:    w_nxt = S_AMT_W;
            key_in == KEY_DEP:    w_nxt = S_AMT_D;
            key_in == KEY_CANCEL: w_nxt = S_IDLE;
`ifdef ATM_MINI_STATEMENT_EN
            key_in == KEY_STMT && !w_log_empty: begin
              w_nxt     = S_STMT;
              w_stmt_go = 1'b1;
            end
`endif
            default: ;
          endcase
        end
        S_AMT_W: if (amount_valid) begin
          w_nxt    = S_MENU;
          w_amt_ld = 1'b1;
          if (amount_in == '0) w_err = ERR_ZERO;
          else if (w_amt_x > w_bal_x) w_err = ERR_FUNDS;
          else if (w_sum_x + w_amt_x > X_LIM) w_err = ERR_LIMIT;
          else if (w_amt_x > X_THR) w_nxt = S_AUTH_FACE;
          else w_nxt = S_DISPENSE;
        end
        S_AMT_D: if (amount_valid) begin
          w_nxt    = S_MENU;
          w_amt_ld = 1'b1;
          if (amount_in == '0) w_err = ERR_ZERO;
          else if (w_bal_x + w_amt_x > X_MAX) w_err = ERR_OVF;
          else w_nxt = S_DEPOSIT;
        end
        S_AUTH_FACE: if (face_recognition_passed) w_nxt = S_AUTH_OTP;
        S_AUTH_OTP: begin
          if (otp_passed) begin
            w_nxt = S_DISPENSE;
          end else if (otp_failed) begin
            w_nxt = S_MENU;
            w_err = ERR_OTP;
          end
        end
        S_DISPENSE: if (dispense_ack) begin
          w_nxt      = S_MENU;
          w_wdr_done = 1'b1;
        end
        S_DEPOSIT: if (deposit_ack) begin
          w_nxt      = S_MENU;
          w_dep_done = 1'b1;
        end
`ifdef ATM_MINI_STATEMENT_EN
        S_STMT: if (w_log_last) w_nxt = S_MENU;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_err   <= ERR_NONE;
    end else begin
      r_state <= w_nxt;
      r_err   <= w_err;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_tmr <= '0;
    else if (!w_tmr_on || w_evt) r_tmr <= '0;
    else r_tmr <= r_tmr + TMW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_card_pin <= '0;
      r_digits   <= '0;
      r_dcnt     <= '0;
      r_tries    <= '0;
      r_bal      <= '0;
      r_sum      <= '0;
      r_amt      <= '0;
    end else begin
      if (w_latch) begin
        r_card_pin <= card_pin;
        r_bal      <= card_balance;
        r_tries    <= '0;
        r_sum      <= '0;
        r_digits   <= '0;
        r_dcnt     <= '0;
      end
      if (w_shift) begin
        r_digits <= PW'({r_digits, key_in});
        r_dcnt   <= r_dcnt + DW'(1);
      end
      if (w_pin_clr) begin
        r_digits <= '0;
        r_dcnt   <= '0;
      end
      if (w_try_inc) r_tries <= r_tries + TW'(1);
      if (w_amt_ld) r_amt <= amount_in;
      if (w_wdr_done) begin
        r_bal <= r_bal - w_amt_b;
        r_sum <= r_sum + w_amt_b;
      end
      if (w_dep_done) r_bal <= r_bal + w_amt_b;
    end
  end

  assign display_data  = {1'b0, r_err, r_state};
  assign balance       = r_bal;
  assign txn_amount    = r_amt;
  assign dispense_cash = (r_state == S_DISPENSE);
  assign deposit_cash  = (r_state == S_DEPOSIT);
  assign face_recognition_required     = (r_state == S_AUTH_FACE);
  assign otp_required                  = (r_state == S_AUTH_OTP);
  assign invalid_pin_attempts_exceeded = (r_state == S_LOCKED);

`ifdef ATM_MINI_STATEMENT_EN
  atm_txn_log #(
    .AMT_W (AMT_W),
    .DEPTH (LOG_DEPTH)
  ) u_log (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_wdr_done | w_dep_done),
    .i_wdata ({w_dep_done, r_amt}),
    .i_start (w_stmt_go),
    .i_rd    (r_state == S_STMT),
    .o_empty (w_log_empty),
    .o_entry (w_log_entry),
    .o_last  (w_log_last)
  );

  assign stmt_valid = (r_state == S_STMT);
  assign stmt_entry = stmt_valid ? w_log_entry : '0;
  assign stmt_last  = stmt_valid & w_log_last;
`else
  assign stmt_valid = 1'b0;
  assign stmt_entry = '0;
  assign stmt_last  = 1'b0;
`endif

endmodule

// File: tb/tb_atm_session_controller.sv
// Scenario bench for atm_session_controller with a randomized
// withdraw/deposit sequence checked against a rule-level account model.
module tb_atm_session_controller;
  localparam int BAL_W   = 16;
  localparam int AMT_W   = 12;
  localparam int THRESH  = 500;
  localparam int LIMIT   = 1000;
  localparam int TMO     = 1024;
  localparam int BAL_MAX = 65535;

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_PIN  = 4'd1;
  localparam logic [3:0] ST_MENU = 4'd2;
  localparam logic [3:0] ST_AMTW = 4'd3;
  localparam logic [3:0] ST_AMTD = 4'd4;
  localparam logic [3:0] ST_FACE = 4'd5;
  localparam logic [3:0] ST_OTP  = 4'd6;
  localparam logic [3:0] ST_DISP = 4'd7;
  localparam logic [3:0] ST_DEP  = 4'd8;
  localparam logic [3:0] ST_LOCK = 4'd9;

  logic clk = 1'b0;
  logic reset;
  logic card_inserted;
  logic [15:0] card_pin;
  logic [BAL_W-1:0] card_balance;
  logic key_valid;
  logic [3:0] key_in;
  logic amount_valid;
  logic [AMT_W-1:0] amount_in;
  logic face_recognition_passed, otp_passed, otp_failed;
  logic dispense_ack, deposit_ack;
  logic [7:0] display_data;
  logic [BAL_W-1:0] balance;
  logic dispense_cash, deposit_cash;
  logic [AMT_W-1:0] txn_amount;
  logic face_recognition_required, otp_required;
  logic invalid_pin_attempts_exceeded;
  logic stmt_valid, stmt_last;
  logic [AMT_W:0] stmt_entry;

  int errors = 0;
  int checks = 0;
  int m_bal;
  int m_sum;
  logic [AMT_W:0] m_log[$];

  always #5 clk = ~clk;

  atm_session_controller #(
    .BAL_W(BAL_W), .AMT_W(AMT_W), .PIN_DIGITS(4), .MAX_PIN_TRIES(3),
    .AUTH_THRESH(THRESH), .DAILY_LIMIT(LIMIT), .TIMEOUT_CYC(TMO), .LOG_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .card_inserted(card_inserted),
    .card_pin(card_pin), .card_balance(card_balance),
    .key_valid(key_valid), .key_in(key_in),
    .amount_valid(amount_valid), .amount_in(amount_in),
    .face_recognition_passed(face_recognition_passed),
    .otp_passed(otp_passed), .otp_failed(otp_failed),
    .dispense_ack(dispense_ack), .deposit_ack(deposit_ack),
    .display_data(display_data), .balance(balance),
    .dispense_cash(dispense_cash), .deposit_cash(deposit_cash),
    .txn_amount(txn_amount),
    .face_recognition_required(face_recognition_required),
    .otp_required(otp_required),
    .invalid_pin_attempts_exceeded(invalid_pin_attempts_exceeded),
    .stmt_valid(stmt_valid), .stmt_entry(stmt_entry), .stmt_last(stmt_last)
  );

  function automatic logic [3:0] st();
    return display_data[3:0];
  endfunction

  function automatic logic [2:0] er();
    return display_data[6:4];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    key_in = k; key_valid = 1'b1; tick(); key_valid = 1'b0;
  endtask

  task automatic enter_amt(input int a);
    amount_in = AMT_W'(a); amount_valid = 1'b1; tick(); amount_valid = 1'b0;
  endtask

  task automatic face_ok();
    face_recognition_passed = 1'b1; tick(); face_recognition_passed = 1'b0;
  endtask

  task automatic otp_ok();
    otp_passed = 1'b1; tick(); otp_passed = 1'b0;
  endtask

  task automatic otp_bad();
    otp_failed = 1'b1; tick(); otp_failed = 1'b0;
  endtask

  task automatic ack_disp();
    dispense_ack = 1'b1; tick(); dispense_ack = 1'b0;
  endtask

  task automatic ack_dep();
    deposit_ack = 1'b1; tick(); deposit_ack = 1'b0;
  endtask

  task automatic start_session(input logic [15:0] pin, input int bal);
    card_inserted = 1'b0; tick(); tick();
    card_pin = pin; card_balance = BAL_W'(bal); card_inserted = 1'b1;
    tick();
    for (int i = 3; i >= 0; i--) press(pin[4*i +: 4]);
    tick();
    m_bal = bal; m_sum = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; card_inserted = 1'b0; card_pin = '0; card_balance = '0;
    key_valid = 1'b0; key_in = '0; amount_valid = 1'b0; amount_in = '0;
    face_recognition_passed = 1'b0; otp_passed = 1'b0; otp_failed = 1'b0;
    dispense_ack = 1'b0; deposit_ack = 1'b0;
    repeat (3) tick();
    checks++; if (display_data !== 8'h00) begin errors++; $display("FAIL reset_display: got %h want 00", display_data); end
    checks++; if (balance !== '0) begin errors++; $display("FAIL reset_balance: got %0d want 0", balance); end
    checks++; if ({dispense_cash, deposit_cash, face_recognition_required, otp_required,
                   invalid_pin_attempts_exceeded, stmt_valid, stmt_last} !== 7'b0) begin
      errors++; $display("FAIL reset_flags: got nonzero output flags want 0");
    end
    reset = 1'b0; tick();
    checks++; if (st() !== ST_IDLE) begin errors++; $display("FAIL reset_idle: state %0d want %0d", st(), ST_IDLE); end
  endtask

  task automatic test_login_withdraw();
    card_pin = 16'h1234; card_balance = 16'd800; card_inserted = 1'b1;
    tick();
    checks++; if (st() !== ST_PIN) begin errors++; $display("FAIL login_pin: state %0d want %0d", st(), ST_PIN); end
    checks++; if (balance !== 16'd800) begin errors++; $display("FAIL login_bal: got %0d want 800", balance); end
    press(4'h1); press(4'h2); press(4'hA); press(4'h3); press(4'h4);
    tick();
    checks++; if (st() !== ST_MENU) begin errors++; $display("FAIL login_menu: state %0d want %0d", st(), ST_MENU); end
    m_bal = 800; m_sum = 0;
    press(4'h4);
    checks++; if (st() !== ST_MENU || stmt_valid !== 1'b0) begin
      errors++; $display("FAIL stmt_empty: state %0d valid %b want %0d 0", st(), stmt_valid, ST_MENU);
    end
    press(4'h1);
    checks++; if (st() !== ST_AMTW) begin errors++; $display("FAIL wdr_amt: state %0d want %0d", st(), ST_AMTW); end
    enter_amt(200);
    checks++; if (dispense_cash !== 1'b1 || txn_amount !== 12'd200) begin
      errors++; $display("FAIL wdr_req: dispense %b amt %0d want 1 200", dispense_cash, txn_amount);
    end
    repeat (3) tick();
    checks++; if (dispense_cash !== 1'b1) begin errors++; $display("FAIL wdr_hold: dispense %b want 1", dispense_cash); end
    ack_disp();
    m_bal -= 200; m_sum += 200; m_log.push_back({1'b0, 12'd200});
    checks++; if (dispense_cash !== 1'b0 || st() !== ST_MENU || balance !== 16'(m_bal)) begin
      errors++; $display("FAIL wdr_done: dispense %b state %0d bal %0d want 0 %0d %0d", dispense_cash, st(), balance, ST_MENU, m_bal);
    end
  endtask

  task automatic test_auth();
    start_session(16'h4321, 800);
    press(4'h1); enter_amt(600);
    checks++; if (st() !== ST_FACE || face_recognition_required !== 1'b1 || otp_required !== 1'b0) begin
      errors++; $display("FAIL auth_face: state %0d face %b otp %b want %0d 1 0", st(), face_recognition_required, otp_required, ST_FACE);
    end
    face_ok();
    checks++; if (st() !== ST_OTP || otp_required !== 1'b1 || face_recognition_required !== 1'b0) begin
      errors++; $display("FAIL auth_otp: state %0d otp %b face %b want %0d 1 0", st(), otp_required, face_recognition_required, ST_OTP);
    end
    otp_bad();
    checks++; if (st() !== ST_MENU || er() !== 3'd5) begin
      errors++; $display("FAIL auth_fail: state %0d err %0d want %0d 5", st(), er(), ST_MENU);
    end
    press(4'h1);
    checks++; if (er() !== 3'd0) begin errors++; $display("FAIL err_clear: err %0d want 0", er()); end
    enter_amt(600); face_ok(); otp_ok();
    checks++; if (st() !== ST_DISP || txn_amount !== 12'd600) begin
      errors++; $display("FAIL auth_disp: state %0d amt %0d want %0d 600", st(), txn_amount, ST_DISP);
    end
    ack_disp();
    m_bal -= 600; m_sum += 600; m_log.push_back({1'b0, 12'd600});
    checks++; if (balance !== 16'(m_bal)) begin errors++; $display("FAIL auth_bal: got %0d want %0d", balance, m_bal); end
  endtask

  task automatic test_limits();
    start_session(16'h9905, 800);
    press(4'h1); enter_amt(900);
    checks++; if (st() !== ST_MENU || er() !== 3'd2) begin
      errors++; $display("FAIL funds: state %0d err %0d want %0d 2", st(), er(), ST_MENU);
    end
    repeat (3) tick();
    checks++; if (er() !== 3'd2) begin errors++; $display("FAIL err_hold: err %0d want 2", er()); end
    press(4'h1); enter_amt(0);
    checks++; if (er() !== 3'd1) begin errors++; $display("FAIL zero_wdr: err %0d want 1", er()); end
    start_session(16'h0007, 2000);
    press(4'h1); enter_amt(600); face_ok(); otp_ok(); ack_disp();
    m_bal -= 600; m_sum += 600; m_log.push_back({1'b0, 12'd600});
    press(4'h1); enter_amt(500);
    checks++; if (st() !== ST_MENU || er() !== 3'd3) begin
      errors++; $display("FAIL daily: state %0d err %0d want %0d 3", st(), er(), ST_MENU);
    end
    press(4'h1); enter_amt(400);
    checks++; if (st() !== ST_DISP) begin errors++; $display("FAIL daily_edge: state %0d want %0d", st(), ST_DISP); end
    ack_disp();
    m_bal -= 400; m_sum += 400; m_log.push_back({1'b0, 12'd400});
    checks++; if (balance !== 16'(m_bal)) begin errors++; $display("FAIL daily_bal: got %0d want %0d", balance, m_bal); end
  endtask

  task automatic test_deposit();
    start_session(16'h2580, 65000);
    press(4'h2);
    checks++; if (st() !== ST_AMTD) begin errors++; $display("FAIL dep_amt: state %0d want %0d", st(), ST_AMTD); end
    enter_amt(BAL_MAX - 65000 + 1);
    checks++; if (st() !== ST_MENU || er() !== 3'd4) begin
      errors++; $display("FAIL dep_ovf: state %0d err %0d want %0d 4", st(), er(), ST_MENU);
    end
    press(4'h2); enter_amt(0);
    checks++; if (er() !== 3'd1) begin errors++; $display("FAIL dep_zero: err %0d want 1", er()); end
    press(4'h2); enter_amt(BAL_MAX - 65000);
    checks++; if (deposit_cash !== 1'b1 || txn_amount !== 12'd535) begin
      errors++; $display("FAIL dep_req: deposit %b amt %0d want 1 535", deposit_cash, txn_amount);
    end
    ack_dep();
    m_bal = BAL_MAX; m_log.push_back({1'b1, 12'd535});
    checks++; if (deposit_cash !== 1'b0 || balance !== 16'(m_bal)) begin
      errors++; $display("FAIL dep_done: deposit %b bal %0d want 0 %0d", deposit_cash, balance, m_bal);
    end
  endtask

  task automatic test_card_pull();
    start_session(16'h1111, 800);
    press(4'h1); enter_amt(100);
    checks++; if (dispense_cash !== 1'b1) begin errors++; $display("FAIL pull_req: dispense %b want 1", dispense_cash); end
    card_inserted = 1'b0; tick();
    checks++; if (st() !== ST_IDLE || dispense_cash !== 1'b0 || balance !== 16'd800) begin
      errors++; $display("FAIL pull: state %0d dispense %b bal %0d want %0d 0 800", st(), dispense_cash, balance, ST_IDLE);
    end
  endtask

  task automatic test_lockout();
    card_inserted = 1'b0; tick(); tick();
    card_pin = 16'h1234; card_balance = 16'd500; card_inserted = 1'b1;
    tick();
    press(4'h5); press(4'hF);
    checks++; if (st() !== ST_IDLE) begin errors++; $display("FAIL pin_cancel: state %0d want %0d", st(), ST_IDLE); end
    tick();
    for (int t = 1; t <= 3; t++) begin
      repeat (4) press(4'h1);
      tick();
      if (t < 3) begin
        checks++; if (st() !== ST_PIN || er() !== 3'd7) begin
          errors++; $display("FAIL wrong_pin%0d: state %0d err %0d want %0d 7", t, st(), er(), ST_PIN);
        end
      end
    end
    checks++; if (st() !== ST_LOCK || invalid_pin_attempts_exceeded !== 1'b1) begin
      errors++; $display("FAIL locked: state %0d exc %b want %0d 1", st(), invalid_pin_attempts_exceeded, ST_LOCK);
    end
    repeat (5) tick();
    checks++; if (st() !== ST_LOCK) begin errors++; $display("FAIL lock_hold: state %0d want %0d", st(), ST_LOCK); end
    card_inserted = 1'b0; tick();
    checks++; if (st() !== ST_IDLE || invalid_pin_attempts_exceeded !== 1'b0) begin
      errors++; $display("FAIL unlock: state %0d exc %b want %0d 0", st(), invalid_pin_attempts_exceeded, ST_IDLE);
    end
  endtask

  task automatic test_timeout();
    int n;
    start_session(16'h1234, 800);
    press(4'h7);
    n = 0;
    while (st() == ST_MENU && n < 2 * TMO) begin
      tick();
      n++;
    end
    checks++; if (n !== TMO || st() !== ST_IDLE || er() !== 3'd6) begin
      errors++; $display("FAIL timeout: cycles %0d state %0d err %0d want %0d %0d 6", n, st(), er(), TMO, ST_IDLE);
    end
  endtask

  task automatic test_random();
    int a, e, r;
    bit dep;
    for (int i = 0; i < 24; i++) begin
      if (i % 8 == 0) begin
        case (i / 8)
          0: start_session(16'h1234, 900);
          1: start_session(16'h1234, 64800);
          default: start_session(16'h1234, int'($urandom_range(0, 3000)));
        endcase
      end
      dep = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 7));
      if (r == 0) a = 0;
      else if (r == 1) a = THRESH;
      else if (r == 2) a = THRESH + 1;
      else a = int'($urandom_range(1, 1200));
      if (a == 0) e = 1;
      else if (!dep && a > m_bal) e = 2;
      else if (!dep && m_sum + a > LIMIT) e = 3;
      else if (dep && m_bal + a > BAL_MAX) e = 4;
      else e = 0;
      press(dep ? 4'h2 : 4'h1);
      enter_amt(a);
      if (e != 0) begin
        checks++; if (st() !== ST_MENU || er() !== 3'(e)) begin
          errors++; $display("FAIL rnd%0d_err: dep %0d amt %0d state %0d err %0d want %0d %0d", i, dep, a, st(), er(), ST_MENU, e);
        end
      end else begin
        if (!dep && a > THRESH) begin
          checks++; if (st() !== ST_FACE) begin errors++; $display("FAIL rnd%0d_face: state %0d want %0d", i, st(), ST_FACE); end
          face_ok(); otp_ok();
        end
        checks++; if (st() !== (dep ? ST_DEP : ST_DISP) || txn_amount !== 12'(a)) begin
          errors++; $display("FAIL rnd%0d_req: dep %0d state %0d amt %0d want amt %0d", i, dep, st(), txn_amount, a);
        end
        if (dep) ack_dep(); else ack_disp();
        if (dep) m_bal += a;
        else begin m_bal -= a; m_sum += a; end
        m_log.push_back({dep, 12'(a)});
      end
      checks++; if (balance !== 16'(m_bal) || st() !== ST_MENU) begin
        errors++; $display("FAIL rnd%0d_bal: bal %0d state %0d want %0d %0d", i, balance, st(), m_bal, ST_MENU);
      end
    end
  endtask

  task automatic test_statement();
    int n;
    start_session(16'h1234, 100);
    n = (m_log.size() > 4) ? 4 : m_log.size();
    press(4'h4);
`ifdef ATM_MINI_STATEMENT_EN
    for (int i = 0; i < n; i++) begin
      checks++; if (stmt_valid !== 1'b1 || stmt_entry !== m_log[m_log.size() - 1 - i] ||
                    stmt_last !== (i == n - 1)) begin
        errors++; $display("FAIL stmt%0d: valid %b entry %h last %b want 1 %h %b", i, stmt_valid, stmt_entry, stmt_last,
                           m_log[m_log.size() - 1 - i], (i == n - 1));
      end
      tick();
    end
`endif
    checks++; if (st() !== ST_MENU || stmt_valid !== 1'b0 || stmt_last !== 1'b0) begin
      errors++; $display("FAIL stmt_end: state %0d valid %b last %b want %0d 0 0 (log %0d)", st(), stmt_valid, stmt_last, ST_MENU, n);
    end
  endtask

  initial begin
    test_reset();
    test_login_withdraw();
    test_auth();
    test_limits();
    test_deposit();
    test_card_pull();
    test_lockout();
    test_timeout();
    test_random();
    test_statement();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
